// File: rtl/alu_pkg.sv
// Shared constants for the Lab3 ALU: function codes and controller state encoding.
// The display path decodes state_o with the same encoding, so keep these in sync.
package alu_pkg;

    localparam logic [3:0] FN_PASS_A = 4'b0000;
    localparam logic [3:0] FN_PASS_B = 4'b0001;
    localparam logic [3:0] FN_ADD    = 4'b0010;
    localparam logic [3:0] FN_SUB    = 4'b0011;
    localparam logic [3:0] FN_MOD3   = 4'b0100;
    localparam int         FN_SIGNED_BIT = 3;

    localparam logic [2:0] ST_LOAD_A = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_ADD    = 3'd2;
    localparam logic [2:0] ST_SUB    = 3'd3;
    localparam logic [2:0] ST_MOD3   = 3'd4;

    // Signedness only matters to the arithmetic functions, never to the operand loads.
    function automatic logic [3:0] fn_for_state(input logic [2:0] st, input logic mode);
        logic [3:0] code;
        code = FN_PASS_A;
        case (st)
            ST_LOAD_A: code = FN_PASS_A;
            ST_LOAD_B: code = FN_PASS_B;
            ST_ADD:    code = FN_ADD;
            ST_SUB:    code = FN_SUB;
            ST_MOD3:   code = FN_MOD3;
            default:   code = FN_PASS_A;
        endcase
        if (st == ST_ADD || st == ST_SUB || st == ST_MOD3) begin
            code[FN_SIGNED_BIT] = mode;
        end
        return code;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level.
// History flop resets high so a button held through reset must be released first.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b1;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/alu_ctrl.sv
// Lab3 ALU sequencing controller: loads operands A and B from the switches,
// then steps ADD -> SUB -> MOD3 on each enter press; sign toggles signed mode.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FN_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enter,
    input  logic             sign,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [FN_W-1:0]  fn,
    output logic             signed_mode,
    output logic [2:0]       state_o
);

    logic             enter_pulse;
    logic             sign_pulse;
    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [WIDTH-1:0] next_a;
    logic [WIDTH-1:0] next_b;
    logic             next_mode;

    edge_detect u_enter_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (enter),
        .pulse (enter_pulse)
    );

    edge_detect u_sign_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (sign),
        .pulse (sign_pulse)
    );

    always_comb begin
        next_state = state;
        next_a     = op_a;
        next_b     = op_b;
        case (state)
            ST_LOAD_A: if (enter_pulse) begin
                next_a     = sw_in;
                next_state = ST_LOAD_B;
            end
            ST_LOAD_B: if (enter_pulse) begin
                next_b     = sw_in;
                next_state = ST_ADD;
            end
            ST_ADD:  if (enter_pulse) next_state = ST_SUB;
            ST_SUB:  if (enter_pulse) next_state = ST_MOD3;
            ST_MOD3: if (enter_pulse) next_state = ST_ADD;
            default: next_state = ST_LOAD_A;
        endcase
    end

    assign next_mode = signed_mode ^ sign_pulse;

    // fn is derived from the next state/mode so it lands on the same edge as the state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_LOAD_A;
            op_a        <= '0;
            op_b        <= '0;
            signed_mode <= 1'b0;
            fn          <= FN_PASS_A;
        end else begin
            state       <= next_state;
            op_a        <= next_a;
            op_b        <= next_b;
            signed_mode <= next_mode;
            fn          <= fn_for_state(next_state, next_mode);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: a reference model pushes expected outputs
// to a scoreboard queue as each cycle is driven; test tasks pop and compare.
module tb_alu_ctrl;

    typedef struct {
        logic [2:0] state;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fn;
        logic       mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enter = 1'b0;
    logic       sign = 1'b0;
    logic [7:0] sw_in = 8'h00;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] fn;
    logic       signed_mode;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t e;

    logic [2:0] m_state;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_mode;
    logic       m_enter_q;
    logic       m_sign_q;

    alu_ctrl #(.WIDTH(8), .FN_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enter       (enter),
        .sign        (sign),
        .sw_in       (sw_in),
        .op_a        (op_a),
        .op_b        (op_b),
        .fn          (fn),
        .signed_mode (signed_mode),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_fn(input logic [2:0] st, input logic mode);
        logic [3:0] f;
        case (st)
            3'd0: f = 4'b0000;
            3'd1: f = 4'b0001;
            3'd2: f = {mode, 3'b010};
            3'd3: f = {mode, 3'b011};
            3'd4: f = {mode, 3'b100};
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

    // Drives one cycle of inputs at the falling edge, advances the model, queues its prediction.
    task automatic drive_cycle(input logic r, input logic en, input logic sg, input logic [7:0] sw);
        logic ep;
        logic sp;
        exp_t x;
        @(negedge clk);
        rst_n = r;
        enter = en;
        sign  = sg;
        sw_in = sw;
        if (!r) begin
            m_state = 3'd0; m_a = 8'h00; m_b = 8'h00; m_mode = 1'b0;
            m_enter_q = 1'b1; m_sign_q = 1'b1;
        end else begin
            ep = en & ~m_enter_q;
            sp = sg & ~m_sign_q;
            m_enter_q = en;
            m_sign_q  = sg;
            if (sp) m_mode = ~m_mode;
            if (ep) begin
                case (m_state)
                    3'd0: begin m_a = sw; m_state = 3'd1; end
                    3'd1: begin m_b = sw; m_state = 3'd2; end
                    3'd2: m_state = 3'd3;
                    3'd3: m_state = 3'd4;
                    3'd4: m_state = 3'd2;
                    default: m_state = 3'd0;
                endcase
            end
        end
        x.state = m_state; x.a = m_a; x.b = m_b; x.mode = m_mode;
        x.fn = model_fn(m_state, m_mode);
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'h5A);
        e = sb.pop_front();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'hA5);
        e = sb.pop_front();
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL reset_state got %0d want %0d", state_o, e.state); end
        checks++; if (op_a !== e.a) begin errors++; $display("[TB] FAIL reset_op_a got %h want %h", op_a, e.a); end
        checks++; if (op_b !== e.b) begin errors++; $display("[TB] FAIL reset_op_b got %h want %h", op_b, e.b); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL reset_fn got %b want %b", fn, e.fn); end
        checks++; if (signed_mode !== e.mode) begin errors++; $display("[TB] FAIL reset_mode got %b want %b", signed_mode, e.mode); end
    endtask

    task automatic test_load_operands();
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h05);
        e = sb.pop_front();
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL idle_state got %0d want %0d", state_o, e.state); end
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h05);
        e = sb.pop_front();
        checks++; if (op_a !== e.a) begin errors++; $display("[TB] FAIL load_a got %h want %h", op_a, e.a); end
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL load_a_state got %0d want %0d", state_o, e.state); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL load_a_fn got %b want %b", fn, e.fn); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h03);
        e = sb.pop_front();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h03);
        e = sb.pop_front();
        checks++; if (op_a !== e.a) begin errors++; $display("[TB] FAIL load_b_op_a got %h want %h", op_a, e.a); end
        checks++; if (op_b !== e.b) begin errors++; $display("[TB] FAIL load_b got %h want %h", op_b, e.b); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL add_fn got %b want %b", fn, e.fn); end
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL add_state got %0d want %0d", state_o, e.state); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h03);
        e = sb.pop_front();
    endtask

    task automatic test_fn_cycle();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
            e = sb.pop_front();
            checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL cycle_fn[%0d] got %b want %b", i, fn, e.fn); end
            checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL cycle_state[%0d] got %0d want %0d", i, state_o, e.state); end
            checks++; if ({op_a, op_b} !== {e.a, e.b}) begin errors++; $display("[TB] FAIL cycle_ops[%0d] got %h/%h want %h/%h", i, op_a, op_b, e.a, e.b); end
            drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
        end
    endtask

    task automatic test_ignore_sw();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'hAA);
        e = sb.pop_front();
        checks++; if (op_a !== e.a) begin errors++; $display("[TB] FAIL ignore_sw_a got %h want %h", op_a, e.a); end
        checks++; if (op_b !== e.b) begin errors++; $display("[TB] FAIL ignore_sw_b got %h want %h", op_b, e.b); end
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL ignore_sw_state got %0d want %0d", state_o, e.state); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'hAA);
        e = sb.pop_front();
    endtask

    task automatic test_hold_enter();
        logic [2:0] prev;
        int advances;
        prev = state_o;
        advances = 0;
        for (int i = 0; i < 100; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 8'h77);
            e = sb.pop_front();
            if (state_o !== prev) advances++;
            prev = state_o;
            checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL hold_state[%0d] got %0d want %0d", i, state_o, e.state); end
        end
        checks++; if (advances != 1) begin errors++; $display("[TB] FAIL hold_advances got %0d want 1", advances); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h77);
        e = sb.pop_front();
    endtask

    task automatic test_sign();
        while (m_state != 3'd3) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
            e = sb.pop_front();
            drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
            e = sb.pop_front();
        end
        drive_cycle(1'b1, 1'b0, 1'b1, 8'h00);
        e = sb.pop_front();
        checks++; if (signed_mode !== e.mode) begin errors++; $display("[TB] FAIL sign_mode got %b want %b", signed_mode, e.mode); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL sign_fn got %b want %b", fn, e.fn); end
        checks++; if ({op_a, op_b} !== {e.a, e.b}) begin errors++; $display("[TB] FAIL sign_ops got %h/%h want %h/%h", op_a, op_b, e.a, e.b); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        e = sb.pop_front();
        drive_cycle(1'b1, 1'b1, 1'b1, 8'h00);
        e = sb.pop_front();
        checks++; if (signed_mode !== e.mode) begin errors++; $display("[TB] FAIL both_mode got %b want %b", signed_mode, e.mode); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL both_fn got %b want %b", fn, e.fn); end
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL both_state got %0d want %0d", state_o, e.state); end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        e = sb.pop_front();
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, 1'b0, 1'b0, 8'hFF);
        e = sb.pop_front();
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL mid_reset_state got %0d want %0d", state_o, e.state); end
        checks++; if ({op_a, op_b} !== {e.a, e.b}) begin errors++; $display("[TB] FAIL mid_reset_ops got %h/%h want %h/%h", op_a, op_b, e.a, e.b); end
        checks++; if (fn !== e.fn) begin errors++; $display("[TB] FAIL mid_reset_fn got %b want %b", fn, e.fn); end
        checks++; if (signed_mode !== e.mode) begin errors++; $display("[TB] FAIL mid_reset_mode got %b want %b", signed_mode, e.mode); end
    endtask

    task automatic test_hold_through_reset();
        drive_cycle(1'b0, 1'b1, 1'b1, 8'h11);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b1, 8'h11);
            e = sb.pop_front();
            checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL held_state[%0d] got %0d want %0d", i, state_o, e.state); end
            checks++; if (signed_mode !== e.mode) begin errors++; $display("[TB] FAIL held_mode[%0d] got %b want %b", i, signed_mode, e.mode); end
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 8'h11);
        e = sb.pop_front();
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h22);
        e = sb.pop_front();
        checks++; if (state_o !== e.state) begin errors++; $display("[TB] FAIL repress_state got %0d want %0d", state_o, e.state); end
        checks++; if (op_a !== e.a) begin errors++; $display("[TB] FAIL repress_op_a got %h want %h", op_a, e.a); end
    endtask

    initial begin
        m_state = 3'd0; m_a = 8'h00; m_b = 8'h00; m_mode = 1'b0;
        m_enter_q = 1'b1; m_sign_q = 1'b1;
        test_reset();
        test_load_operands();
        test_fn_cycle();
        test_ignore_sw();
        test_hold_enter();
        test_sign();
        test_reset_mid();
        test_hold_through_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
